// File: rtl/csel_pair_stage_if.sv
`default_nettype none
// ============================================================================
// Module      : csel_pair_stage_if
// Description : Handshake and result bus of the carry-select operand stage.
//               Upstream supplies operand pairs, downstream consumes the
//               candidate sums. The ovf0/ovf1 signals exist only when the
//               CSEL_OVF_EN macro is defined.
// Revision    : 1.0 - initial release
// ============================================================================
interface csel_pair_stage_if #(
  parameter int W     = 16,
  parameter int DEPTH = 2
);

  localparam int c_ow = $clog2(DEPTH + 1);

  logic            in_valid;
  logic            in_ready;
  logic [W-1:0]    a;
  logic [W-1:0]    b;
  logic            out_valid;
  logic            out_ready;
  logic [W-1:0]    sum0;
  logic [W-1:0]    sum1;
  logic            cout0;
  logic            cout1;
  logic [c_ow-1:0] occ;
`ifdef CSEL_OVF_EN
  logic            ovf0;
  logic            ovf1;
`endif

  // Producer/consumer side (drives operands and consumes results).
  modport master (
    output in_valid, a, b, out_ready,
    input  in_ready, out_valid, sum0, sum1, cout0, cout1, occ
`ifdef CSEL_OVF_EN
    , ovf0, ovf1
`endif
  );

  // Stage side.
  modport slave (
    input  in_valid, a, b, out_ready,
    output in_ready, out_valid, sum0, sum1, cout0, cout1, occ
`ifdef CSEL_OVF_EN
    , ovf0, ovf1
`endif
  );

endinterface
`default_nettype wire

// File: rtl/csel_pair_stage.sv
`default_nettype none
// ============================================================================
// Module      : csel_pair_stage
// Description : Registered operand stage for a carry-select adder. Computes
//               a+b and a+b+1 (with carry-outs) for each accepted operand
//               pair and queues both candidates in an in-order FIFO whose
//               head feeds the carry-select mux.
//               Optional feature macro: CSEL_OVF_EN (signed overflow flags).
// Revision    : 1.0 - initial release
// ============================================================================
module csel_pair_stage #(
  parameter int W     = 16,
  parameter int DEPTH = 2
) (
  input wire               clk,
  input wire               rst_n,
  csel_pair_stage_if.slave bus
);

  localparam int              c_pw   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int              c_ow   = $clog2(DEPTH + 1);
  localparam logic [c_ow-1:0] c_full = c_ow'(DEPTH);

  // FIFO bookkeeping
  logic [c_pw-1:0] r_wr_ptr;
  logic [c_pw-1:0] r_rd_ptr;
  logic [c_pw-1:0] r_last_ptr;  // slot of the most recently popped entry
  logic [c_ow-1:0] r_occ;

  // FIFO storage
  logic [W-1:0]    r_sum0  [DEPTH];
  logic [W-1:0]    r_sum1  [DEPTH];
  logic            r_cout0 [DEPTH];
  logic            r_cout1 [DEPTH];
`ifdef CSEL_OVF_EN
  logic            r_ovf0  [DEPTH];
  logic            r_ovf1  [DEPTH];
  logic            w_ovf0;
  logic            w_ovf1;
`endif

  logic            w_push;
  logic            w_pop;
  logic            w_empty;
  logic [W:0]      w_add0;
  logic [W:0]      w_add1;
  logic [c_pw-1:0] w_head_idx;

  // Full/empty come from the occupancy count only, never from pointers.
  assign w_empty = (r_occ == '0);
  assign w_push  = bus.in_valid && (r_occ != c_full);
  assign w_pop   = bus.out_ready && !w_empty;

  // Both candidate sums in W+1-bit unsigned arithmetic; the +1 variant is
  // an increment of the plain sum, so only one full-width adder is needed.
  assign w_add0 = {1'b0, bus.a} + {1'b0, bus.b};
  assign w_add1 = w_add0 + 1'b1;

`ifdef CSEL_OVF_EN
  // Signed overflow: operands agree in sign but the result sign differs.
  assign w_ovf0 = (bus.a[W-1] == bus.b[W-1]) && (w_add0[W-1] != bus.a[W-1]);
  assign w_ovf1 = (bus.a[W-1] == bus.b[W-1]) && (w_add1[W-1] != bus.a[W-1]);
`endif

  // Pointer and occupancy update; push and pop together leave occ unchanged.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_last_ptr <= '0;
      r_occ      <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr   <= r_rd_ptr + 1'b1;
        r_last_ptr <= r_rd_ptr;
      end
      case ({w_push, w_pop})
        2'b10:   r_occ <= r_occ + 1'b1;
        2'b01:   r_occ <= r_occ - 1'b1;
        default: r_occ <= r_occ;
      endcase
    end
  end

  // Result storage; cleared on reset so an idle output reads zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_sum0[i]  <= '0;
        r_sum1[i]  <= '0;
        r_cout0[i] <= 1'b0;
        r_cout1[i] <= 1'b0;
`ifdef CSEL_OVF_EN
        r_ovf0[i]  <= 1'b0;
        r_ovf1[i]  <= 1'b0;
`endif
      end
    end else if (w_push) begin
      r_sum0[r_wr_ptr]  <= w_add0[W-1:0];
      r_sum1[r_wr_ptr]  <= w_add1[W-1:0];
      r_cout0[r_wr_ptr] <= w_add0[W];
      r_cout1[r_wr_ptr] <= w_add1[W];
`ifdef CSEL_OVF_EN
      r_ovf0[r_wr_ptr]  <= w_ovf0;
      r_ovf1[r_wr_ptr]  <= w_ovf1;
`endif
    end
  end

  // When empty the read pointer already points past the last head, so the
  // outputs are steered to the last popped slot to keep the old value. That
  // slot cannot be overwritten while empty because writes go to r_rd_ptr.
  assign w_head_idx = w_empty ? r_last_ptr : r_rd_ptr;

  assign bus.in_ready  = (r_occ != c_full);
  assign bus.out_valid = !w_empty;
  assign bus.occ       = r_occ;
  assign bus.sum0      = r_sum0[w_head_idx];
  assign bus.sum1      = r_sum1[w_head_idx];
  assign bus.cout0     = r_cout0[w_head_idx];
  assign bus.cout1     = r_cout1[w_head_idx];
`ifdef CSEL_OVF_EN
  assign bus.ovf0      = r_ovf0[w_head_idx];
  assign bus.ovf1      = r_ovf1[w_head_idx];
`endif

endmodule
`default_nettype wire

// File: tb/tb_csel_pair_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_csel_pair_stage
// Description : Self-checking bench for csel_pair_stage. A queue-based
//               reference model tracks the FIFO contents; entries are
//               computed with integer arithmetic from the operands.
//               Optional feature macro: CSEL_OVF_EN (signed overflow flags).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_csel_pair_stage;

  localparam int W     = 16;
  localparam int DEPTH = 2;

  typedef struct packed {
    logic [15:0] s0;
    logic [15:0] s1;
    logic        c0;
    logic        c1;
    logic        o0;
    logic        o1;
  } ent_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  csel_pair_stage_if #(.W(W), .DEPTH(DEPTH)) bus ();

  csel_pair_stage #(.W(W), .DEPTH(DEPTH)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  ent_t q[$];
  ent_t last_head;
  int   tests = 0;
  int   fails = 0;

  // Reference entry from plain integer arithmetic.
  function automatic ent_t ref_ent(input logic [15:0] a, input logic [15:0] b);
    ent_t        e;
    int unsigned t0;
    int unsigned t1;
    int          sa;
    int          sb;
    t0   = int'(a) + int'(b);
    t1   = t0 + 1;
    e.s0 = t0[15:0];
    e.c0 = t0[16];
    e.s1 = t1[15:0];
    e.c1 = t1[16];
    sa   = int'($signed(a));
    sb   = int'($signed(b));
    e.o0 = ((sa + sb) > 32767) || ((sa + sb) < -32768);
    e.o1 = ((sa + sb + 1) > 32767) || ((sa + sb + 1) < -32768);
    return e;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Compare every DUT output with the model state.
  task automatic check_all(input string ph);
    ent_t h;
    h = (q.size() != 0) ? q[0] : last_head;
    chk({ph, "/out_valid"}, 32'(bus.out_valid), 32'(q.size() != 0));
    chk({ph, "/in_ready"},  32'(bus.in_ready),  32'(q.size() != DEPTH));
    chk({ph, "/occ"},       32'(bus.occ),       q.size());
    chk({ph, "/sum0"},      32'(bus.sum0),      32'(h.s0));
    chk({ph, "/sum1"},      32'(bus.sum1),      32'(h.s1));
    chk({ph, "/cout0"},     32'(bus.cout0),     32'(h.c0));
    chk({ph, "/cout1"},     32'(bus.cout1),     32'(h.c1));
`ifdef CSEL_OVF_EN
    chk({ph, "/ovf0"},      32'(bus.ovf0),      32'(h.o0));
    chk({ph, "/ovf1"},      32'(bus.ovf1),      32'(h.o1));
`endif
    if (q.size() != 0) last_head = q[0];
  endtask

  // One clock: drive at negedge, model at posedge, check at next negedge.
  task automatic step(input string ph, input logic iv, input logic [15:0] ia,
                      input logic [15:0] ib, input logic ordy);
    bit   push;
    bit   pop;
    ent_t e;
    bus.in_valid  = iv;
    bus.a         = ia;
    bus.b         = ib;
    bus.out_ready = ordy;
    push = iv && (q.size() != DEPTH);
    pop  = ordy && (q.size() != 0);
    e    = ref_ent(ia, ib);
    @(posedge clk);
    if (pop)  void'(q.pop_front());
    if (push) q.push_back(e);
    @(negedge clk);
    check_all(ph);
  endtask

  function automatic logic [15:0] pick_operand();
    case ($urandom_range(0, 5))
      0:       return 16'hFFFF;
      1:       return 16'h7FFF;
      2:       return 16'h8000;
      3:       return 16'h0000;
      default: return 16'($urandom());
    endcase
  endfunction

  initial begin
    bus.in_valid  = 1'b0;
    bus.a         = '0;
    bus.b         = '0;
    bus.out_ready = 1'b0;
    last_head     = '0;

    // Reset state
    repeat (2) @(negedge clk);
    check_all("reset");
    rst_n = 1'b1;
    @(negedge clk);
    check_all("post_reset");

    // Basic push, visible for exactly one cycle
    step("basic", 1'b1, 16'h1234, 16'h4321, 1'b1);
    chk("basic_sum0",  32'(bus.sum0),      32'h5555);
    chk("basic_sum1",  32'(bus.sum1),      32'h5556);
    chk("basic_cout0", 32'(bus.cout0),     32'h0);
    chk("basic_cout1", 32'(bus.cout1),     32'h0);
    chk("basic_valid", 32'(bus.out_valid), 32'h1);
    step("basic_drain", 1'b0, 16'h0000, 16'h0000, 1'b1);
    chk("basic_one_cycle", 32'(bus.out_valid), 32'h0);

    // Carry boundaries
    step("carry_a", 1'b1, 16'hFFFF, 16'h0001, 1'b1);
    chk("carry_a_sum0",  32'(bus.sum0),  32'h0000);
    chk("carry_a_cout0", 32'(bus.cout0), 32'h1);
    chk("carry_a_sum1",  32'(bus.sum1),  32'h0001);
    chk("carry_a_cout1", 32'(bus.cout1), 32'h1);
    step("carry_b", 1'b1, 16'hFFFF, 16'h0000, 1'b1);
    chk("carry_b_sum0",  32'(bus.sum0),  32'hFFFF);
    chk("carry_b_cout0", 32'(bus.cout0), 32'h0);
    chk("carry_b_sum1",  32'(bus.sum1),  32'h0000);
    chk("carry_b_cout1", 32'(bus.cout1), 32'h1);
    step("idle", 1'b0, 16'h0000, 16'h0000, 1'b1);

    // Backpressure: two accepts then stall, head held
    step("bp0", 1'b1, 16'hAAAA, 16'h1111, 1'b0);
    step("bp1", 1'b1, 16'hBBBB, 16'h2222, 1'b0);
    chk("bp_occ_full",  32'(bus.occ),      32'h2);
    chk("bp_not_ready", 32'(bus.in_ready), 32'h0);
    step("bp2", 1'b1, 16'hCCCC, 16'h3333, 1'b0);
    chk("bp_hold_occ",  32'(bus.occ),  32'h2);
    chk("bp_hold_sum0", 32'(bus.sum0), 32'hBBBB);
    // First pop while full: third pair still refused this edge
    step("bp_pop1", 1'b1, 16'hCCCC, 16'h3333, 1'b1);
    chk("bp_pop1_occ",  32'(bus.occ),  32'h1);
    chk("bp_pop1_sum0", 32'(bus.sum0), 32'hDDDD);
    // Third pair accepted alongside the second pop
    step("bp_acc3", 1'b1, 16'hCCCC, 16'h3333, 1'b1);
    chk("simul_occ",  32'(bus.occ),  32'h1);
    chk("simul_sum0", 32'(bus.sum0), 32'hFFFF);

    // Ten consecutive pairs through several pointer wraps
    for (int i = 0; i < 10; i++) begin
      step("wrap", 1'b1, 16'($urandom()), 16'($urandom()), 1'b1);
    end
    step("wrap_drain", 1'b0, 16'h0000, 16'h0000, 1'b1);

    // Asynchronous reset in the middle of a cycle with occ=2
    step("pre_rst0", 1'b1, 16'h0102, 16'h0304, 1'b0);
    step("pre_rst1", 1'b1, 16'h0506, 16'h0708, 1'b0);
    #2;
    rst_n        = 1'b0;
    bus.in_valid = 1'b1;
    #1;
    chk("rst_now_valid", 32'(bus.out_valid), 32'h0);
    chk("rst_now_occ",   32'(bus.occ),       32'h0);
    q.delete();
    last_head = '0;
    @(posedge clk);
    @(negedge clk);
    check_all("in_reset");
    rst_n        = 1'b1;
    bus.in_valid = 1'b0;
    @(negedge clk);
    check_all("rst_release");
    chk("rst_ready", 32'(bus.in_ready), 32'h1);

`ifdef CSEL_OVF_EN
    step("ovf_a", 1'b1, 16'h7FFF, 16'h0000, 1'b1);
    chk("ovf_a_ovf0", 32'(bus.ovf0), 32'h0);
    chk("ovf_a_ovf1", 32'(bus.ovf1), 32'h1);
    step("ovf_b", 1'b1, 16'h8000, 16'h8000, 1'b1);
    chk("ovf_b_ovf0", 32'(bus.ovf0), 32'h1);
    chk("ovf_b_ovf1", 32'(bus.ovf1), 32'h1);
`endif

    // Randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      step("rand", 1'($urandom_range(0, 3) != 0), pick_operand(), pick_operand(),
           1'($urandom_range(0, 2) != 0));
    end
    step("final_drain0", 1'b0, 16'h0000, 16'h0000, 1'b1);
    step("final_drain1", 1'b0, 16'h0000, 16'h0000, 1'b1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/csel_pair_stage.md
# csel_pair_stage

Registered operand stage that feeds the carry-select output mux. It accepts a W-bit operand pair through a valid/ready handshake and computes both candidate sums, `a+b` (carry-in 0) and `a+b+1` (carry-in 1), with their carry-outs. It buffers the results in a small in-order FIFO. Its `sum0`/`sum1` outputs drive the mux's `i0`/`i1` inputs directly. The lower slice's carry later selects between them.

## Interface
- `W`, 16: operand and sum width.
- `DEPTH`, 2: FIFO entries; must be a power of two and at least 2.

- `clk`: in, 1. Rising-edge clock.
- `rst_n`: in, 1. Asynchronous, active-low reset.
- `in_valid`: in, 1. Operand pair valid.
- `in_ready`: out, 1. Stage can accept an operand pair.
- `a`: in, W. Operand A.
- `b`: in, W. Operand B.
- `out_valid`: out, 1. Head entry valid.
- `out_ready`: in, 1. Downstream consumes the head entry.
- `sum0`: out, W. Head entry `a+b`, truncated to W bits; drives mux `i0`.
- `sum1`: out, W. Head entry `a+b+1`, truncated to W bits; drives mux `i1`.
- `cout0`: out, 1. Carry-out of `a+b`.
- `cout1`: out, 1. Carry-out of `a+b+1`.
- `occ`: out, clog2(DEPTH+1). Number of valid entries.
- `ovf0`, `ovf1`: out, 1 each. Signed overflow of `sum0`/`sum1`. Present only with `CSEL_OVF_EN` (see Configuration).

## Operation
- Push occurs when `in_valid && in_ready`.
  - The stage computes `{cout0,sum0} = a + b` and `{cout1,sum1} = a + b + 1`, both in W+1-bit unsigned arithmetic.
  - Both results are written into the FIFO at the write pointer.
- Pop occurs when `out_valid && out_ready`. It advances the read pointer.
- FIFO ordering and pointers:
  - Strictly in order.
  - Read and write pointers wrap modulo DEPTH.
  - Full and empty are derived from `occ`, never from pointer equality alone.
- `in_ready = (occ != DEPTH)`. It is registered-state only and has no combinational path from `out_ready`. When full, a same-cycle pop does not allow a push.
- `out_valid = (occ != 0)`. The head outputs (`sum0`, `sum1`, `cout0`, `cout1`, flags) come from the head entry.
- Push and pop in the same cycle (only possible when 0 < occ < DEPTH): `occ` is unchanged and both pointers advance.
- Push while full is impossible by construction. Pop while empty is ignored.
- While `out_valid && !out_ready`, all head outputs hold stable.
- When `out_valid` is 0, the output values are don't-care but deterministic: they hold the last head value, or 0 after reset.
- Reset behaviour:
  - Asserting `rst_n` low at any time immediately clears the pointers and `occ`.
  - `out_valid` = 0 and `in_ready` = 1 after deassertion.
  - `sum0`, `sum1`, `cout0`, `cout1`, `ovf0` and `ovf1` read 0.
  - An in-flight push in the cycle reset asserts is discarded.

## Timing
- Latency: a pair pushed at rising edge k appears with `out_valid` = 1 in cycle k+1, i.e. after that edge.
- Throughput: one pair per cycle while neither end stalls.
- All outputs are driven from flops or from a FIFO read mux indexed by a registered pointer. There is no combinational input-to-output path.
- Adders sit between the `a`/`b` inputs and the FIFO write port: a single W-bit add plus an increment, within one cycle.

## Configuration
- `CSEL_OVF_EN` defined:
  - Each entry additionally stores `ovf0 = (a[W-1]==b[W-1]) && (sum0[W-1]!=a[W-1])`, and `ovf1` computed the same way using `sum1`.
  - Both are output alongside the head entry and reset to 0.
- Not defined: the `ovf0`/`ovf1` ports and their storage are absent. All other behaviour is identical.

## Test plan
- Basic push: `a`=0x1234, `b`=0x4321, `out_ready`=1.
  - Next cycle: `sum0`=0x5555, `sum1`=0x5556, `cout0`=`cout1`=0, `out_valid`=1 for one cycle.
- Carry boundary: `a`=0xFFFF, `b`=0x0001.
  - Required: `sum0`=0x0000, `cout0`=1, `sum1`=0x0001, `cout1`=1.
- Carry boundary: `a`=0xFFFF, `b`=0x0000.
  - Required: `sum0`=0xFFFF, `cout0`=0, `sum1`=0x0000, `cout1`=1.
- Backpressure: `out_ready`=0, offer 3 pairs back-to-back.
  - Required: `in_ready` drops after 2 accepts and `occ`=2.
  - Head outputs stay stable.
  - Raising `out_ready` drains in order; the third pair is accepted the cycle after the first pop.
- Simultaneous: with `occ`=1, push and pop in the same cycle.
  - Required: `occ` stays 1 and the outputs advance to the new entry.
  - Run 10 consecutive pairs through a full pointer wrap with no loss or reordering.
- Reset mid-operation: `occ`=2, assert `rst_n`=0 asynchronously mid-cycle.
  - Required: immediately `out_valid`=0 and `occ`=0; after release, `in_ready`=1.
- With `CSEL_OVF_EN`: `a`=0x7FFF, `b`=0x0000.
  - Required: `ovf0`=0, `ovf1`=1.
  - With `a`=0x8000, `b`=0x8000: `ovf0`=1, `ovf1`=1.
